cycle_counter_checker: RTL and testbench

//  Consumer-side checker for the free-running cycle_counter output. Samples ctr_i on v_i and

---
 rtl/cycle_counter_pkg.sv | 16 +
 rtl/cycle_counter_checker_if.sv | 16 +
 rtl/cycle_counter_checker_sat_counter.sv | 23 ++
 rtl/cycle_counter_checker.sv | 134 +++++++++++++
 tb/tb_cycle_counter_checker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cycle_counter_pkg.sv
// Shared definitions for the cycle counter and its consumer-side checker.
// Holds default widths so producer and checker agree, plus the checker state type.
package cycle_counter_pkg;

  localparam int unsigned ctr_width_dflt     = 32;
  localparam int unsigned err_cnt_width_dflt = 16;
  localparam int unsigned resync_thresh_dflt = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    RESYNC  = 2'd3
  } ctr_chk_state_e;

endpackage

// File: rtl/cycle_counter_checker_if.sv
// Count interface between a free-running counter (master) and its reader (slave).
// Handshake: v_i high means ctr_i holds a sample to be consumed on this clock edge.
// There is no back-pressure; the reader takes every valid sample or ignores it.
interface cycle_counter_checker_if
  import cycle_counter_pkg::*;
#(
  parameter int unsigned width_p = ctr_width_dflt
);

  logic               v_i;
  logic [width_p-1:0] ctr_i;

  modport master (output v_i, output ctr_i);
  modport slave  (input  v_i, input  ctr_i);

endinterface

// File: rtl/cycle_counter_checker_sat_counter.sv
// Saturating event counter: sticks at all-ones, synchronous clear has priority.
module sat_counter #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [width_p-1:0] cnt_o
);

  // Count up on inc_i until all-ones; clear overrides a same-cycle increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {width_p{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/cycle_counter_checker.sv
// Consumer-side checker for a free-running cycle counter. Keeps its own expected
// count (advancing every clock once acquired), compares each accepted sample and
// reports mismatches with a registered pulse and a saturating error count.
// Optional: define CTR_CHECK_SNAPSHOT_EN to add err_exp_o/err_act_o, which hold the
// expected and observed values of the first mismatch after reset or clear.
module cycle_counter_checker
  import cycle_counter_pkg::*;
#(
  parameter int unsigned width_p         = ctr_width_dflt,
  parameter int unsigned err_cnt_width_p = err_cnt_width_dflt,
  parameter int unsigned resync_thresh_p = resync_thresh_dflt
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic                       clr_i,
  cycle_counter_checker_if.slave     cnt,
  output logic                       locked_o,
  output logic                       err_o,
  output logic [err_cnt_width_p-1:0] err_cnt_o,
  output logic [width_p-1:0]         exp_o,
  output ctr_chk_state_e             state_o
`ifdef CTR_CHECK_SNAPSHOT_EN
  ,
  output logic [width_p-1:0]         err_exp_o,
  output logic [width_p-1:0]         err_act_o
`endif
);

  localparam int unsigned gc_w = (resync_thresh_p > 1) ? $clog2(resync_thresh_p) : 1;
  localparam logic [gc_w-1:0] good_last = gc_w'(resync_thresh_p - 1);

  ctr_chk_state_e     state_q, state_d;
  logic [width_p-1:0] exp_q;
  logic [gc_w-1:0]    good_q;
  logic               err_q;

  logic accept, checking, hit, miss;

  assign accept   = cnt.v_i & en_i;
  assign checking = (state_q == LOCKED) || (state_q == RESYNC);
  assign hit      = (cnt.ctr_i == exp_q);
  assign miss     = accept & checking & ~hit;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; dropping enable returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (accept) state_d = LOCKED;
        LOCKED:  if (miss) state_d = RESYNC;
        RESYNC:  if (accept && hit && (good_q == good_last)) state_d = LOCKED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state and datapath.
  always_comb begin
    state_o  = state_q;
    locked_o = (state_q == LOCKED);
    err_o    = err_q;
    exp_o    = exp_q;
  end

  // Expected count: seeded from the first sample, then free-runs; reseeded on a miss.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      exp_q <= '0;
    end else if (en_i) begin
      if (state_q == ACQUIRE) begin
        if (accept) exp_q <= cnt.ctr_i + 1'b1;
      end else if (checking) begin
        exp_q <= miss ? (cnt.ctr_i + 1'b1) : (exp_q + 1'b1);
      end
    end
  end

  // Run of consecutive good samples while resynchronising.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      good_q <= '0;
    end else if (miss) begin
      good_q <= '0;
    end else if (en_i && (state_q == RESYNC) && accept && hit) begin
      good_q <= (good_q == good_last) ? '0 : (good_q + 1'b1);
    end
  end

  // Mismatch pulse, one cycle after the offending sample.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= miss;
  end

  sat_counter #(.width_p(err_cnt_width_p)) u_err_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (clr_i),
    .inc_i   (miss),
    .cnt_o   (err_cnt_o)
  );

`ifdef CTR_CHECK_SNAPSHOT_EN
  logic snap_taken_q;

  // Capture the first mismatch only; clear re-arms and zeroes the snapshot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      snap_taken_q <= 1'b0;
      err_exp_o    <= '0;
      err_act_o    <= '0;
    end else if (clr_i) begin
      snap_taken_q <= 1'b0;
      err_exp_o    <= '0;
      err_act_o    <= '0;
    end else if (miss && !snap_taken_q) begin
      snap_taken_q <= 1'b1;
      err_exp_o    <= exp_q;
      err_act_o    <= cnt.ctr_i;
    end
  end
`endif

endmodule

// File: tb/tb_cycle_counter_checker.sv
// Directed bench for cycle_counter_checker (8-bit count, 2-bit error counter).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_cycle_counter_checker;
  import cycle_counter_pkg::*;

  localparam int unsigned w  = 8;
  localparam int unsigned ew = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          en_i;
  logic          clr_i;
  logic          locked_o;
  logic          err_o;
  logic [ew-1:0] err_cnt_o;
  logic [w-1:0]  exp_o;
  ctr_chk_state_e state_o;
`ifdef CTR_CHECK_SNAPSHOT_EN
  logic [w-1:0]  err_exp_o;
  logic [w-1:0]  err_act_o;
`endif

  cycle_counter_checker_if #(.width_p(w)) cif ();

  cycle_counter_checker #(
    .width_p         (w),
    .err_cnt_width_p (ew),
    .resync_thresh_p (4)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .cnt       (cif),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .exp_o     (exp_o),
    .state_o   (state_o)
`ifdef CTR_CHECK_SNAPSHOT_EN
    ,
    .err_exp_o (err_exp_o),
    .err_act_o (err_act_o)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [w-1:0] cnt_ref;
  logic [w-1:0] hold_exp;
  int bad;
  int wrap_sample;
  int sat_tab [5] = '{1, 2, 3, 3, 3};

  initial begin
    // 1: reset, then idle with enable low and a valid sample present.
    reset_i   = 1'b1;
    en_i      = 1'b0;
    clr_i     = 1'b0;
    cif.v_i   = 1'b1;
    cif.ctr_i = 8'h55;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    chk("t1_locked",  32'(locked_o),  32'd0);
    chk("t1_err",     32'(err_o),     32'd0);
    chk("t1_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("t1_exp",     32'(exp_o),     32'd0);
    chk("t1_state",   32'(state_o),   32'(IDLE));

    // 2: continuous sampling from a free-running counter.
    cnt_ref   = 8'h10;
    en_i      = 1'b1;
    cif.ctr_i = cnt_ref;
    tick();
    chk("t2_acquire", 32'(state_o), 32'(ACQUIRE));
    chk("t2_acq_exp", 32'(exp_o),   32'd0);
    cnt_ref++;
    cif.ctr_i = cnt_ref;
    tick();
    chk("t2_locked",  32'(locked_o), 32'd1);
    chk("t2_exp",     32'(exp_o),    32'h12);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cnt_ref++;
      cif.ctr_i = cnt_ref;
      tick();
      if (err_o || !locked_o) bad++;
    end
    chk("t2_no_err",     32'(bad),       32'd0);
    chk("t2_err_cnt",    32'(err_cnt_o), 32'd0);
    chk("t2_exp_end",    32'(exp_o),     32'hFA);

    // 3: one sample forced to exp+5, then the counter carries on from there.
    cnt_ref++;
    cif.ctr_i = cnt_ref + 8'd5;
    tick();
    chk("t3_err",     32'(err_o),     32'd1);
    chk("t3_err_cnt", 32'(err_cnt_o), 32'd1);
    chk("t3_locked",  32'(locked_o),  32'd0);
    chk("t3_state",   32'(state_o),   32'(RESYNC));
    chk("t3_exp",     32'(exp_o),     32'h00);
`ifdef CTR_CHECK_SNAPSHOT_EN
    chk("t3_snap_exp", 32'(err_exp_o), 32'hFA);
    chk("t3_snap_act", 32'(err_act_o), 32'hFF);
`endif
    cnt_ref = 8'hFF;
    cnt_ref++;
    cif.ctr_i = cnt_ref;
    tick();
    chk("t3_err_clear", 32'(err_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cnt_ref++;
      cif.ctr_i = cnt_ref;
      tick();
    end
    chk("t3_not_yet", 32'(locked_o), 32'd0);
    cnt_ref++;
    cif.ctr_i = cnt_ref;
    tick();
    chk("t3_relock", 32'(locked_o), 32'd1);

    // 4: sparse sampling (every 3rd cycle) across the 8'hFF -> 8'h00 wrap.
    bad         = 0;
    wrap_sample = 0;
    for (int i = 0; i < 300; i++) begin
      cnt_ref++;
      cif.ctr_i = cnt_ref;
      cif.v_i   = ((i % 3) == 0);
      if (cif.v_i && (cnt_ref == 8'h00)) wrap_sample = 1;
      tick();
      if (err_o || !locked_o) bad++;
    end
    chk("t4_no_err",   32'(bad),         32'd0);
    chk("t4_wrap",     32'(wrap_sample), 32'd1);
    chk("t4_err_cnt",  32'(err_cnt_o),   32'd1);
    chk("t4_exp",      32'(exp_o),       32'h30);

    // 5: clear, then five mismatches saturate the 2-bit counter.
    cif.v_i = 1'b0;
    clr_i   = 1'b1;
    cnt_ref++;
    cif.ctr_i = cnt_ref;
    tick();
    clr_i = 1'b0;
    chk("t5_clr", 32'(err_cnt_o), 32'd0);
`ifdef CTR_CHECK_SNAPSHOT_EN
    chk("t5_snap_clr", 32'(err_exp_o), 32'd0);
`endif
    cif.v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cnt_ref++;
      cif.ctr_i = cnt_ref + 8'd5;
      tick();
      cnt_ref = cnt_ref + 8'd5;
      chk("t5_err_pulse", 32'(err_o),     32'd1);
      chk("t5_sat",       32'(err_cnt_o), 32'(sat_tab[i]));
    end
`ifdef CTR_CHECK_SNAPSHOT_EN
    chk("t5_snap_exp", 32'(err_exp_o), 32'h31);
    chk("t5_snap_act", 32'(err_act_o), 32'h36);
`endif

    // Enable low: mismatching sample ignored, count kept, expected value held.
    hold_exp  = cnt_ref + 8'd1;
    en_i      = 1'b0;
    cif.ctr_i = cnt_ref + 8'd9;
    tick();
    chk("dis_state",   32'(state_o),   32'(IDLE));
    chk("dis_err",     32'(err_o),     32'd0);
    chk("dis_err_cnt", 32'(err_cnt_o), 32'd3);
    chk("dis_exp",     32'(exp_o),     32'(hold_exp));
    tick();
    chk("dis_exp_hold", 32'(exp_o), 32'(hold_exp));

    // Re-acquire, then clear coinciding with a mismatch.
    en_i    = 1'b1;
    cif.v_i = 1'b0;
    tick();
    cif.v_i   = 1'b1;
    cif.ctr_i = 8'h40;
    tick();
    chk("reacq_locked", 32'(locked_o), 32'd1);
    chk("reacq_exp",    32'(exp_o),    32'h41);
    cif.ctr_i = 8'h47;
    clr_i     = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clrmiss_err",     32'(err_o),     32'd1);
    chk("clrmiss_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("clrmiss_state",   32'(state_o),   32'(RESYNC));
    chk("clrmiss_exp",     32'(exp_o),     32'h48);

    // 6: asynchronous reset mid-RESYNC.
    cif.ctr_i = 8'h50;
    tick();
    chk("t6_pre_cnt", 32'(err_cnt_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("t6_locked",  32'(locked_o),  32'd0);
    chk("t6_err",     32'(err_o),     32'd0);
    chk("t6_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("t6_exp",     32'(exp_o),     32'd0);
    chk("t6_state",   32'(state_o),   32'(IDLE));
`ifdef CTR_CHECK_SNAPSHOT_EN
    chk("t6_snap_act", 32'(err_act_o), 32'd0);
`endif
    tick();
    reset_i   = 1'b0;
    cif.ctr_i = 8'h80;
    tick();
    chk("t6_acquire", 32'(state_o), 32'(ACQUIRE));
    cif.ctr_i = 8'h81;
    tick();
    chk("t6_relock",     32'(locked_o), 32'd1);
    chk("t6_relock_exp", 32'(exp_o),    32'h82);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
